// File: rtl/tc7_interval_counter_pkg.sv
// Shared constants and types for the tc7 interval counter.
// Width and reset period defaults live here so the top and its bench agree.
package tc7_interval_counter_pkg;

  localparam int TC_WIDTH        = 7;
  localparam int TC_RESET_PERIOD = 0;

  typedef enum logic {
    MODE_RELOAD = 1'b0,
    MODE_ONCE   = 1'b1
  } tc_mode_e;

endpackage

// File: rtl/tc7_interval_counter_allones_decode.sv
// All-ones detector for the counter value: active-high flag for internal use
// and the active-low terminal-count decode driven off-block.
module tc_allones_decode #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] value,
  output logic             all_ones,
  output logic             tcl
);

  assign all_ones = &value;
  assign tcl      = ~all_ones;

endmodule

// File: rtl/tc7_interval_counter.sv
// Programmable up-counter with period register, auto-reload / one-shot mode,
// registered terminal-count strobe and a latched interrupt.
module tc7_interval_counter
  import tc7_interval_counter_pkg::*;
#(
  parameter int WIDTH        = TC_WIDTH,
  parameter int RESET_PERIOD = TC_RESET_PERIOD
) (
  input  logic             clk,
  input  logic             resetl,
  input  logic [WIDTH-1:0] din,
  input  logic             ld_per,
  input  logic             ld_cnt,
  input  logic             en,
  input  logic             once,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] cnt,
  output logic             tcl,
  output logic             tc_pulse,
  output logic             irq,
  output logic             running
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             running_q, running_d;
  logic             tc_pulse_q, tc_pulse_d;
  logic             irq_q, irq_d;
  logic             all_ones_s;
  logic             tce_s;
  tc_mode_e         mode_s;

  tc_allones_decode #(.WIDTH(WIDTH)) u_decode (
    .value    (cnt_q),
    .all_ones (all_ones_s),
    .tcl      (tcl)
  );

  // A load in the same cycle masks the terminal-count event.
  assign tce_s  = running_q & en & all_ones_s & ~ld_cnt;
  assign mode_s = tc_mode_e'(once);

  always_comb begin
    cnt_d     = cnt_q;
    running_d = running_q;
    if (ld_cnt) begin
      cnt_d     = din;
      running_d = 1'b1;
    end else if (tce_s) begin
      case (mode_s)
        MODE_RELOAD: cnt_d     = period_q;
        MODE_ONCE:   running_d = 1'b0;
        default:     running_d = 1'b0;
      endcase
    end else if (running_q && en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else begin
      cnt_d     = cnt_q;
      running_d = running_q;
    end
  end

  always_comb begin
    period_d   = ld_per ? din : period_q;
    tc_pulse_d = tce_s;
    // Set has priority over acknowledge so a coincident event is never lost.
    if (tce_s) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      cnt_q      <= {WIDTH{1'b0}};
      period_q   <= WIDTH'(RESET_PERIOD);
      running_q  <= 1'b0;
      tc_pulse_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      running_q  <= running_d;
      tc_pulse_q <= tc_pulse_d;
      irq_q      <= irq_d;
    end
  end

  assign cnt      = cnt_q;
  assign tc_pulse = tc_pulse_q;
  assign irq      = irq_q;
  assign running  = running_q;

endmodule

// File: tb/tb_tc7_interval_counter.sv
// Self-checking bench for tc7_interval_counter: vector table, corner-case
// sequences and random stimulus against a cycle-level reference model.
module tb_tc7_interval_counter;

  localparam int W   = 7;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         resetl;
  logic [W-1:0] din;
  logic         ld_per, ld_cnt, en, once, irq_ack;
  logic [W-1:0] cnt;
  logic         tcl, tc_pulse, irq, running;

  int n_cmp = 0;
  int n_bad = 0;

  int m_cnt, m_per, m_run, m_irq, m_pulse;

  typedef struct {
    int din; int lp; int lc; int en; int once; int ack;
    int e_cnt; int e_tcl; int e_pulse; int e_irq; int e_run;
  } vec_t;

  vec_t vec[18];

  tc7_interval_counter dut (
    .clk      (clk),
    .resetl   (resetl),
    .din      (din),
    .ld_per   (ld_per),
    .ld_cnt   (ld_cnt),
    .en       (en),
    .once     (once),
    .irq_ack  (irq_ack),
    .cnt      (cnt),
    .tcl      (tcl),
    .tc_pulse (tc_pulse),
    .irq      (irq),
    .running  (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, " cnt"},      int'(cnt),      m_cnt);
    chk({tag, " tcl"},      int'(tcl),      (m_cnt == MAX) ? 0 : 1);
    chk({tag, " tc_pulse"}, int'(tc_pulse), m_pulse);
    chk({tag, " irq"},      int'(irq),      m_irq);
    chk({tag, " running"},  int'(running),  m_run);
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic cyc(input int d, input int lp, input int lc, input int e,
                     input int o, input int a);
    int tce, nc, nr;
    din = W'(d); ld_per = lp[0]; ld_cnt = lc[0]; en = e[0]; once = o[0]; irq_ack = a[0];
    tce = (m_run != 0 && e != 0 && m_cnt == MAX && lc == 0) ? 1 : 0;
    nc = m_cnt;
    nr = m_run;
    if (lc != 0) begin
      nc = d; nr = 1;
    end else if (tce != 0 && o == 0) begin
      nc = m_per;
    end else if (tce != 0) begin
      nr = 0;
    end else if (m_run != 0 && e != 0) begin
      nc = (m_cnt + 1) % (MAX + 1);
    end
    if (lp != 0) m_per = d;
    m_cnt = nc;
    m_run = nr;
    m_pulse = tce;
    if (tce != 0) m_irq = 1;
    else if (a != 0) m_irq = 0;
    @(posedge clk);
    #1;
    model_check("model");
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    #2;
    resetl = 1'b0;
    din = '0; ld_per = 1'b0; ld_cnt = 1'b0; en = 1'b0; once = 1'b0; irq_ack = 1'b0;
    #1;
    chk("reset cnt", int'(cnt), 0);
    chk("reset tcl", int'(tcl), 1);
    chk("reset tc_pulse", int'(tc_pulse), 0);
    chk("reset irq", int'(irq), 0);
    chk("reset running", int'(running), 0);
    m_cnt = 0; m_per = 0; m_run = 0; m_irq = 0; m_pulse = 0;
    @(posedge clk);
    #1;
    resetl = 1'b1;
  endtask

  initial begin
    resetl = 1'b0;
    din = '0; ld_per = 1'b0; ld_cnt = 1'b0; en = 1'b0; once = 1'b0; irq_ack = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // din lp lc en once ack | cnt tcl pulse irq run
    vec[0]  = '{'h7C, 1, 0, 0, 0, 0, 'h00, 1, 0, 0, 0};
    vec[1]  = '{'h7C, 0, 1, 1, 0, 0, 'h7C, 1, 0, 0, 1};
    vec[2]  = '{0,    0, 0, 1, 0, 0, 'h7D, 1, 0, 0, 1};
    vec[3]  = '{0,    0, 0, 1, 0, 0, 'h7E, 1, 0, 0, 1};
    vec[4]  = '{0,    0, 0, 1, 0, 0, 'h7F, 0, 0, 0, 1};
    vec[5]  = '{0,    0, 0, 1, 0, 0, 'h7C, 1, 1, 1, 1};
    vec[6]  = '{0,    0, 0, 1, 0, 0, 'h7D, 1, 0, 1, 1};
    vec[7]  = '{0,    0, 0, 1, 0, 0, 'h7E, 1, 0, 1, 1};
    vec[8]  = '{0,    0, 0, 1, 0, 0, 'h7F, 0, 0, 1, 1};
    vec[9]  = '{0,    0, 0, 1, 0, 0, 'h7C, 1, 1, 1, 1};
    vec[10] = '{'h7E, 0, 1, 1, 1, 0, 'h7E, 1, 0, 1, 1};
    vec[11] = '{0,    0, 0, 1, 1, 0, 'h7F, 0, 0, 1, 1};
    vec[12] = '{0,    0, 0, 1, 1, 0, 'h7F, 0, 1, 1, 0};
    vec[13] = '{0,    0, 0, 1, 1, 0, 'h7F, 0, 0, 1, 0};
    vec[14] = '{0,    0, 0, 1, 0, 0, 'h7F, 0, 0, 1, 0};
    vec[15] = '{0,    0, 0, 0, 0, 1, 'h7F, 0, 0, 0, 0};
    vec[16] = '{'h7F, 0, 1, 1, 0, 0, 'h7F, 0, 0, 0, 1};
    vec[17] = '{'h20, 0, 1, 1, 0, 0, 'h20, 1, 0, 0, 1};

    for (int i = 0; i < 18; i++) begin
      cyc(vec[i].din, vec[i].lp, vec[i].lc, vec[i].en, vec[i].once, vec[i].ack);
      chk($sformatf("tbl[%0d] cnt", i),      int'(cnt),      vec[i].e_cnt);
      chk($sformatf("tbl[%0d] tcl", i),      int'(tcl),      vec[i].e_tcl);
      chk($sformatf("tbl[%0d] tc_pulse", i), int'(tc_pulse), vec[i].e_pulse);
      chk($sformatf("tbl[%0d] irq", i),      int'(irq),      vec[i].e_irq);
      chk($sformatf("tbl[%0d] running", i),  int'(running),  vec[i].e_run);
    end

    // Reset in the middle of a count.
    cyc('h40, 0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0);
    chk("midcount cnt", int'(cnt), 'h45);
    do_reset();

    // Collisions: ack and ld_per in the terminal-count cycle.
    cyc('h7E, 1, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("coll pre cnt", int'(cnt), 'h7F);
    cyc('h10, 1, 0, 1, 0, 1);
    chk("coll old period", int'(cnt), 'h7E);
    chk("coll irq set wins", int'(irq), 1);
    cyc(0, 0, 0, 1, 0, 1);
    chk("coll ack clears", int'(irq), 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("coll new period", int'(cnt), 'h10);
    chk("coll irq again", int'(irq), 1);
    do_reset();

    // Period all ones with enable toggling.
    cyc('h7F, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("gate pulse 1", int'(tc_pulse), 1);
    chk("gate cnt 1", int'(cnt), 'h7F);
    cyc(0, 0, 0, 0, 0, 0);
    chk("gate pulse 0", int'(tc_pulse), 0);
    chk("gate cnt 0", int'(cnt), 'h7F);
    cyc(0, 0, 0, 1, 0, 0);
    chk("gate pulse 2", int'(tc_pulse), 1);
    chk("gate cnt 2", int'(cnt), 'h7F);
    do_reset();

    // Random traffic, biased toward high count/period values.
    for (int i = 0; i < 3000; i++) begin
      int d;
      d = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, MAX))
                                      : int'($urandom_range(MAX - 6, MAX));
      cyc(d,
          ($urandom_range(0, 15) == 0) ? 1 : 0,
          ($urandom_range(0, 19) == 0) ? 1 : 0,
          ($urandom_range(0, 3) != 0) ? 1 : 0,
          ($urandom_range(0, 3) == 0) ? 1 : 0,
          ($urandom_range(0, 7) == 0) ? 1 : 0);
      if (i == 1500) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
